// File: rtl/rom_dual_port_pkg.sv
// Shared constants and the ROM content function for the dual-port ROM.
// Every read port builds its lookup table from rom_word(), so the content
// is defined in exactly one place.
package rom_dual_port_pkg;

  // Default geometry: 16 words of 16 bits.
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 16;

  // Supported data width range. The content function works in 64 bits,
  // which is what bounds DW from above.
  localparam int DW_MIN = 8;
  localparam int DW_MAX = 64;

  // Content generator constants: word(a) = a * ROM_MULT + ROM_OFFSET.
  localparam logic [7:0]  ROM_OFFSET = 8'hA5;
  localparam logic [15:0] ROM_MULT   = 16'h0101;

  // Full 64-bit content word for an address. Callers keep the low DW bits,
  // which gives the reduction mod 2**DW.
  function automatic logic [63:0] rom_word(input logic [63:0] addr);
    logic [63:0] mult_w;
    logic [63:0] offs_w;
    mult_w = 64'(ROM_MULT);
    offs_w = 64'(ROM_OFFSET);
    return (addr * mult_w) + offs_w;
  endfunction

endpackage

// File: rtl/rom_dual_port_read_port.sv
// One registered ROM read port with its own constant lookup table.
//
// Enable semantics: en is a plain qualifier, there is no backpressure.
// A rising clk edge with en=1 loads the addressed word into dout (one cycle
// latency, one word per cycle when en stays high). With en=0 dout holds and
// addr is not looked at, so an undefined address cannot disturb the output.
// Synchronous active-low reset clears dout and wins over en.
module rom_read_port
  import rom_dual_port_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] dout
);

  localparam int DEPTH = 2 ** AW;

  // Constant content, one entry per address; folds to logic at elaboration.
  logic [DW-1:0] rom_table [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [63:0] WORD = rom_word(64'(i));
    assign rom_table[i] = WORD[DW-1:0];
  end

  logic [DW-1:0] dout_d;
  logic [DW-1:0] dout_q;

  // Next output word: new lookup when enabled, otherwise hold.
  always_comb begin
    dout_d = dout_q;
    if (en) begin
      dout_d = rom_table[addr];
    end
  end

  // Output register; reset clears it and overrides any pending read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  // Output comes straight from the register, no input-to-output path.
  assign dout = dout_q;

endmodule

// File: rtl/rom_dual_port.sv
// Dual-port read-only memory: two independent registered read ports over
// the same constant content. The ports share nothing but clk and rst_n, so
// they never stall each other and may read the same address in one cycle.
module rom_dual_port
  import rom_dual_port_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [AW-1:0] addra,
  output logic [DW-1:0] douta,
  input  logic          enb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] doutb
);

  // Port A
  rom_read_port #(
    .AW (AW),
    .DW (DW)
  ) u_port_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .addr  (addra),
    .dout  (douta)
  );

  // Port B
  rom_read_port #(
    .AW (AW),
    .DW (DW)
  ) u_port_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (enb),
    .addr  (addrb),
    .dout  (doutb)
  );

endmodule

// File: tb/tb_rom_dual_port.sv
// Bench for rom_dual_port: table of per-cycle stimulus records with their
// expected outputs, plus hand sequences for reset, hold and glitch cases.
// Expected words go into exp_q when a cycle is driven and are popped and
// compared once the DUT has clocked that cycle.
module tb_rom_dual_port;

  localparam int AW = 4;
  localparam int DW = 16;

  // Clock / reset block
  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          enb;
  logic [AW-1:0] addra;
  logic [AW-1:0] addrb;
  logic [DW-1:0] douta;
  logic [DW-1:0] doutb;

  always #5 clk = ~clk;

  rom_dual_port #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .addra (addra),
    .douta (douta),
    .enb   (enb),
    .addrb (addrb),
    .doutb (doutb)
  );

  typedef struct {
    logic          ena;
    logic [AW-1:0] addra;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  vec_t vecs[$];

  // Scoreboard
  logic [2*DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Running expectations: tbl_* while building the table, cur_* while driving.
  logic [DW-1:0] tbl_a = '0;
  logic [DW-1:0] tbl_b = '0;
  logic [DW-1:0] cur_a = '0;
  logic [DW-1:0] cur_b = '0;

  // Reference content, written independently from the arithmetic formula.
  function automatic logic [DW-1:0] ref_word(input int a);
    int v;
    v = a * 257 + 165;
    return v[DW-1:0];
  endfunction

  // Append one table record, deriving its expected outputs.
  task automatic add_vec(input logic e_a, input int a_a, input logic e_b, input int a_b);
    vec_t v;
    if (e_a) tbl_a = ref_word(a_a);
    if (e_b) tbl_b = ref_word(a_b);
    v.ena   = e_a;
    v.addra = AW'(a_a);
    v.enb   = e_b;
    v.addrb = AW'(a_b);
    v.exp_a = tbl_a;
    v.exp_b = tbl_b;
    vecs.push_back(v);
  endtask

  // Scoreboard compare for the cycle just clocked.
  task automatic check_out(input string name);
    logic [2*DW-1:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (douta !== e[2*DW-1:DW]) begin
        errors++;
        $display("FAIL %s douta: got %h expected %h", name, douta, e[2*DW-1:DW]);
      end
      checks++;
      if (doutb !== e[DW-1:0]) begin
        errors++;
        $display("FAIL %s doutb: got %h expected %h", name, doutb, e[DW-1:0]);
      end
    end
  endtask

  // Driver: apply one cycle of inputs (optionally glitching rst_n low between
  // edges), push the expectation, clock, then compare 1 ns after the edge.
  task automatic drive_cycle(input string name, input logic r, input logic glitch,
                             input logic e_a, input int a_a,
                             input logic e_b, input int a_b,
                             input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    ena   = e_a;
    addra = AW'(a_a);
    enb   = e_b;
    addrb = AW'(a_b);
    if (glitch) begin
      rst_n = 1'b0;
      #2;
    end
    rst_n = r;
    exp_q.push_back({ea, eb});
    cur_a = ea;
    cur_b = eb;
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    enb   = 1'b0;
    addra = '0;
    addrb = '0;
    #1;

    // Reset with both enables high: outputs stay zero throughout.
    for (int i = 0; i < 3; i++) begin
      drive_cycle("reset_hold", 1'b0, 1'b0, 1'b1, 5, 1'b1, 5, 16'h0000, 16'h0000);
    end

    // Build the vector table.
    for (int i = 0; i < 16; i++) add_vec(1'b1, i, 1'b0, 0);          // sweep A
    for (int i = 0; i < 16; i++) add_vec(1'b0, 3, 1'b1, i);          // sweep B
    add_vec(1'b1, 7, 1'b1, 7);                                       // collision
    for (int i = 0; i < 16; i++) add_vec(1'b1, i, 1'b1, 15 - i);     // independence
    add_vec(1'b1, 15, 1'b1, 0);                                      // wrap 15 -> 0
    add_vec(1'b1, 0, 1'b1, 15);
    for (int i = 0; i < 24; i++) begin                               // random mix
      add_vec(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end

    // Apply the table back to back, rst_n held high.
    foreach (vecs[i]) begin
      drive_cycle("table", 1'b1, 1'b0, vecs[i].ena, int'(vecs[i].addra),
                  vecs[i].enb, int'(vecs[i].addrb), vecs[i].exp_a, vecs[i].exp_b);
    end

    // Collision with literal expectations.
    drive_cycle("collision", 1'b1, 1'b0, 1'b1, 7, 1'b1, 7, 16'h07AC, 16'h07AC);

    // Hold: read 3, then disabled with a different address for 4 cycles.
    drive_cycle("hold_load", 1'b1, 1'b0, 1'b1, 3, 1'b0, 9, 16'h03A8, cur_b);
    for (int i = 0; i < 4; i++) begin
      drive_cycle("hold", 1'b1, 1'b0, 1'b0, 9, 1'b0, 9, 16'h03A8, cur_b);
    end

    // A reset glitch between edges must not disturb the outputs.
    drive_cycle("rst_glitch", 1'b1, 1'b1, 1'b0, 1, 1'b0, 1, cur_a, cur_b);

    // Reset mid-stream: sweep, reset during an enabled read, then recover.
    for (int i = 0; i < 4; i++) begin
      drive_cycle("pre_reset", 1'b1, 1'b0, 1'b1, i, 1'b1, i + 8,
                  ref_word(i), ref_word(i + 8));
    end
    drive_cycle("mid_reset", 1'b0, 1'b0, 1'b1, 4, 1'b1, 12, 16'h0000, 16'h0000);
    drive_cycle("post_idle", 1'b1, 1'b0, 1'b0, 5, 1'b0, 13, 16'h0000, 16'h0000);
    drive_cycle("post_read", 1'b1, 1'b0, 1'b1, 2, 1'b0, 2, 16'h02A7, 16'h0000);
    drive_cycle("post_read_b", 1'b1, 1'b0, 1'b0, 2, 1'b1, 15, 16'h02A7, 16'h0FB4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_dual_port.md
ROM_DUAL_PORT -- requirements
Module: rom_dual_port

Interface
REQ-001 Parameter AW, default 4: address width in bits; depth SHALL be 2**AW words.
REQ-002 Parameter DW, default 16: data word width in bits; legal range 8 to 64.
REQ-003 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port ena, input, 1 bit: port A read enable.
REQ-006 Port addra, input, AW bits: port A read address.
REQ-007 Port douta, output, DW bits: port A registered read data.
REQ-008 Port enb, input, 1 bit: port B read enable.
REQ-009 Port addrb, input, AW bits: port B read address.
REQ-010 Port doutb, output, DW bits: port B registered read data.
REQ-011 The interface is fixed: one clock; reset is synchronous and active-low.

Function
REQ-012 ROM content SHALL be ROM_WORD(a) = (a * 16'h0101 + 8'hA5) mod 2**DW for every address a.
- Example with DW=16: a=0 gives 16'h00A5; a=1 gives 16'h01A6; a=15 gives 16'h0FB4.
- Content is constant and elaborated at compile time; there is no write path.
REQ-013 Port A: on a rising clk edge with rst_n=1 and ena=1, douta SHALL load ROM_WORD(addra); read latency is exactly 1 cycle.
REQ-014 Port A: on a rising clk edge with rst_n=1 and ena=0, douta SHALL hold its previous value.
REQ-015 Port B SHALL behave as REQ-013 and REQ-014, using enb, addrb and doutb.
REQ-016 Ports A and B are fully independent and SHALL never stall each other.
- Simultaneous reads of the same address both return the correct word in the same cycle.
REQ-017 Back-to-back reads with the enable held high SHALL give one new word per cycle, with no bubble.
REQ-018 Every address value is in range, including the wrap from 2**AW-1 to 0; no error path exists.
REQ-019 Outputs SHALL be driven directly from registers, with no combinational path from inputs to douta or doutb.
REQ-020 X or Z on an address while its enable is 0 SHALL NOT affect that port's output.

Reset
REQ-021 On a rising clk edge with rst_n=0, douta and doutb SHALL both become all zeros.
REQ-022 Reset SHALL take priority over ena and enb.
REQ-023 After rst_n returns to 1, the first enabled read SHALL produce data on the next edge.
REQ-024 Reset asserted mid-stream SHALL discard any in-flight read; outputs stay zero until a read completes after reset is released.
REQ-025 Asynchronous assertion of rst_n between clock edges SHALL have no effect until the next edge.

Structure
REQ-026 Package rom_dual_port_pkg SHALL hold:
- default constants AW_DEF=4 and DW_DEF=16;
- the constant function rom_word(addr) implementing REQ-012;
- the ROM content constants 8'hA5 (offset) and 16'h0101 (multiplier).
REQ-027 Sub-module rom_read_port (en, addr, dout, clk, rst_n) SHALL be instantiated twice, once for port A and once for port B.
- Each instance holds its own lookup table built from rom_word.

Verification
REQ-028 Reset check: hold rst_n=0 for 3 cycles with ena=enb=1 and addra=addrb=5 -> douta=doutb=0 throughout.
REQ-029 Sweep: ena=1, addra=0..15 on consecutive cycles -> douta=ROM_WORD(addra) one cycle later, e.g. 16'h00A5 through 16'h0FB4; repeat the sweep on port B.
REQ-030 Hold: read address 3, then ena=0 with addra=9 for 4 cycles -> douta stays 16'h03A8.
REQ-031 Collision: ena=enb=1 with addra=addrb=7 -> douta=doutb=16'h07AC on the next edge.
REQ-032 Independence: port A reads 0..15 while port B reads 15 down to 0 on the same cycles -> each port is correct every cycle.
REQ-033 Reset mid-stream: assert rst_n=0 during a sweep -> outputs are 0 on the next edge; after release, the first read of address 2 gives 16'h02A7.
